// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LSU memory port arbiter.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyLsu
  } arb_state_e;

  typedef enum logic {
    OwnIf,
    OwnLsu
  } owner_e;

  // Instruction fetches always read a full word.
  localparam logic [3:0] BE_FULL = 4'hF;

  // Busy state that belongs to a given owner.
  function automatic arb_state_e busy_state(input owner_e owner);
    return (owner == OwnIf) ? StBusyIf : StBusyLsu;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// slave: the arbiter's view; master: pipeline stages plus memory.
interface mem_port_arbiter_if #(
  parameter int unsigned Width = 32
);
  // Fetch stage
  logic             if_req;
  logic [Width-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [Width-1:0] if_rdata;
  // Load/store stage
  logic             lsu_req;
  logic             lsu_we;
  logic [3:0]       lsu_be;
  logic [Width-1:0] lsu_addr;
  logic [Width-1:0] lsu_wdata;
  logic             lsu_gnt;
  logic             lsu_rvalid;
  logic [Width-1:0] lsu_rdata;
  // Memory
  logic             mem_req;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [Width-1:0] mem_addr;
  logic [Width-1:0] mem_wdata;
  logic             mem_rvalid;
  logic [Width-1:0] mem_rdata;
  // Status
  logic             err;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rvalid, mem_rdata,
    output err
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rvalid, mem_rdata,
    input  err
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of LSU grants won while a fetch was waiting. Once it
// reaches StarveMax the fetch is given priority; any fetch grant clears it.
module arb_starve_cnt #(
  parameter int unsigned StarveMax = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lsu_grant_i,  // LSU granted while IF was requesting
  input  logic if_grant_i,
  output logic if_prio_o
);

  localparam int unsigned CntW = (StarveMax < 1) ? 1 : $clog2(StarveMax + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveMax);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear on fetch grant, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (if_grant_i) begin
      cnt_d = '0;
    end else if (lsu_grant_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign if_prio_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and load/store. One access in flight; LSU has priority (older instruction).
// Define MEM_PORT_ARB_FAIRNESS_EN to let a starved fetch win after StarveMax
// consecutive LSU grants.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned Width     = 32,
  parameter int unsigned StarveMax = 4
) (
  input logic            clk_i,
  input logic            rst_ni,
  mem_port_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  owner_e           winner;
  logic             if_prio;
  logic             if_gnt, lsu_gnt;
  logic             mem_req, mem_we;
  logic [3:0]       mem_be;
  logic [Width-1:0] mem_addr, mem_wdata;
  logic             if_rvalid_q, lsu_rvalid_q;
  logic [Width-1:0] if_rdata_q, lsu_rdata_q;
  logic             err_q;

`ifdef MEM_PORT_ARB_FAIRNESS_EN
  arb_starve_cnt #(
    .StarveMax(StarveMax)
  ) u_starve_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .lsu_grant_i(lsu_gnt && bus.if_req),
    .if_grant_i (if_gnt),
    .if_prio_o  (if_prio)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = ^StarveMax;
  assign if_prio           = 1'b0;
`endif

  // Pick the winner among present requests.
  always_comb begin
    winner = OwnLsu;
    if (bus.if_req && (!bus.lsu_req || if_prio)) begin
      winner = OwnIf;
    end
  end

  // Next state plus same-cycle grant and memory command.
  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    lsu_gnt   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.if_req || bus.lsu_req) begin
          mem_req = 1'b1;
          state_d = busy_state(winner);
          if (winner == OwnIf) begin
            if_gnt   = 1'b1;
            mem_be   = BE_FULL;
            mem_addr = bus.if_addr;
          end else begin
            lsu_gnt   = 1'b1;
            mem_we    = bus.lsu_we;
            mem_be    = bus.lsu_be;
            mem_addr  = bus.lsu_addr;
            mem_wdata = bus.lsu_we ? bus.lsu_wdata : '0;
          end
        end
      end
      StBusyIf, StBusyLsu: begin
        if (bus.mem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Route the response to its owner; rdata holds until that owner's next response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_rvalid_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      if_rvalid_q  <= (state_q == StBusyIf) && bus.mem_rvalid;
      lsu_rvalid_q <= (state_q == StBusyLsu) && bus.mem_rvalid;
      if ((state_q == StBusyIf) && bus.mem_rvalid) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if ((state_q == StBusyLsu) && bus.mem_rvalid) begin
        lsu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Sticky error: a response arrived with nothing outstanding (includes L=0
  // and responses to accesses aborted by reset).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((state_q == StIdle) && bus.mem_rvalid) begin
      err_q <= 1'b1;
    end
  end

  assign bus.if_gnt     = if_gnt;
  assign bus.lsu_gnt    = lsu_gnt;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_be     = mem_be;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.lsu_rvalid = lsu_rvalid_q;
  assign bus.lsu_rdata  = lsu_rdata_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus
// hand-written sequences for starvation, reset abort and sticky error.
module tb_mem_port_arbiter;

  localparam int unsigned Width = 32;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.Width(Width)) bus ();

  mem_port_arbiter #(
    .Width    (Width),
    .StarveMax(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        e_if_gnt;
    logic        e_lsu_gnt;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [3:0]  e_mem_be;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_if_rvalid;
    logic        e_lsu_rvalid;
    logic        c_if_rdata;
    logic [31:0] e_if_rdata;
    logic        c_lsu_rdata;
    logic [31:0] e_lsu_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic ifr, input logic [31:0] ifa, input logic lr, input logic lwe,
                     input logic [3:0] lbe, input logic [31:0] la, input logic [31:0] lwd,
                     input logic mrv, input logic [31:0] mrd,
                     input logic eig, input logic elg, input logic emr, input logic ewe,
                     input logic [3:0] ebe, input logic [31:0] ea, input logic [31:0] ewd,
                     input logic eirv, input logic elrv, input logic cir, input logic [31:0] eird,
                     input logic clr, input logic [31:0] elrd, input logic eerr);
    vec_t v;
    v = '{ifr, ifa, lr, lwe, lbe, la, lwd, mrv, mrd, eig, elg, emr, ewe, ebe, ea, ewd,
          eirv, elrv, cir, eird, clr, elrd, eerr};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.lsu_req    = 1'b0;
    bus.lsu_we     = 1'b0;
    bus.lsu_be     = '0;
    bus.lsu_addr   = '0;
    bus.lsu_wdata  = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    step();
  endtask

  int     ng;
  logic   pending;
  logic   order [10];
  logic   exp_if;

  initial begin
    rst_ni = 1'b0;
    // if_req, if_addr, lsu_req, we, be, lsu_addr, wdata, mem_rvalid, mem_rdata |
    // if_gnt, lsu_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_rvalid, lsu_rvalid,
    // chk_if_rdata, if_rdata, chk_lsu_rdata, lsu_rdata, err
    // Reset state
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    // Fetch 0x100, L=2
    add(1, 'h100, 0, 0, 0, 0, 0, 0, 0,
        1, 0, 1, 0, 'hF, 'h100, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'h00500093,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h00500093, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00500093, 1, 0, 0);
    // IF and LSU together: LSU load 0x7F0 (L=1) wins, IF 0x200 granted at c2
    add(1, 'h200, 1, 0, 'hF, 'h7F0, 'h55555555, 0, 0,
        0, 1, 1, 0, 'hF, 'h7F0, 0, 0, 0, 1, 'h00500093, 1, 0, 0);
    add(1, 'h200, 0, 0, 0, 0, 0, 1, 'h11223344,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00500093, 1, 0, 0);
    add(1, 'h200, 0, 0, 0, 0, 0, 0, 0,
        1, 0, 1, 0, 'hF, 'h200, 0, 0, 1, 1, 'h00500093, 1, 'h11223344, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00500093, 1, 'h11223344, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'hCAFEF00D, 1, 'h11223344, 0);
    // Store 0xDEADBEEF, be=0011 to 0x7F4; a fetch shows up while busy and is not granted
    add(0, 0, 1, 1, 'h3, 'h7F4, 'hDEADBEEF, 0, 0,
        0, 1, 1, 1, 'h3, 'h7F4, 'hDEADBEEF, 0, 0, 1, 'hCAFEF00D, 1, 'h11223344, 0);
    add(1, 'h300, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D, 1, 'h11223344, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'h0BADF00D,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D, 1, 'h11223344, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hCAFEF00D, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D, 0, 0, 0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      bus.if_req     = v.if_req;
      bus.if_addr    = v.if_addr;
      bus.lsu_req    = v.lsu_req;
      bus.lsu_we     = v.lsu_we;
      bus.lsu_be     = v.lsu_be;
      bus.lsu_addr   = v.lsu_addr;
      bus.lsu_wdata  = v.lsu_wdata;
      bus.mem_rvalid = v.mem_rvalid;
      bus.mem_rdata  = v.mem_rdata;
      @(negedge clk);
      check($sformatf("v%0d if_gnt", i), 32'(bus.if_gnt), 32'(v.e_if_gnt));
      check($sformatf("v%0d lsu_gnt", i), 32'(bus.lsu_gnt), 32'(v.e_lsu_gnt));
      check($sformatf("v%0d mem_req", i), 32'(bus.mem_req), 32'(v.e_mem_req));
      if (v.e_mem_req) begin
        check($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(v.e_mem_we));
        check($sformatf("v%0d mem_be", i), 32'(bus.mem_be), 32'(v.e_mem_be));
        check($sformatf("v%0d mem_addr", i), bus.mem_addr, v.e_mem_addr);
        check($sformatf("v%0d mem_wdata", i), bus.mem_wdata, v.e_mem_wdata);
      end
      check($sformatf("v%0d if_rvalid", i), 32'(bus.if_rvalid), 32'(v.e_if_rvalid));
      check($sformatf("v%0d lsu_rvalid", i), 32'(bus.lsu_rvalid), 32'(v.e_lsu_rvalid));
      if (v.c_if_rdata) check($sformatf("v%0d if_rdata", i), bus.if_rdata, v.e_if_rdata);
      if (v.c_lsu_rdata) check($sformatf("v%0d lsu_rdata", i), bus.lsu_rdata, v.e_lsu_rdata);
      check($sformatf("v%0d err", i), 32'(bus.err), 32'(v.e_err));
      step();
    end

    // Both requesting continuously, memory answers with L=1.
    do_reset();
    ng      = 0;
    pending = 1'b0;
    for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
      bus.if_req     = 1'b1;
      bus.if_addr    = 'h400;
      bus.lsu_req    = 1'b1;
      bus.lsu_we     = 1'b0;
      bus.lsu_be     = 'hF;
      bus.lsu_addr   = 'h800;
      bus.mem_rvalid = pending;
      bus.mem_rdata  = 32'(cyc);
      @(negedge clk);
      if (bus.if_gnt || bus.lsu_gnt) begin
        order[ng] = bus.if_gnt;
        ng++;
        pending = 1'b1;
      end else begin
        pending = 1'b0;
      end
      step();
    end
    check("starve grant count", 32'(ng), 32'd10);
    for (int i = 0; i < ng; i++) begin
`ifdef MEM_PORT_ARB_FAIRNESS_EN
      exp_if = (i % 5) == 4;
`else
      exp_if = 1'b0;
`endif
      check($sformatf("starve grant%0d is_if", i), 32'(order[i]), 32'(exp_if));
    end

    // Reset pulsed while BUSY_LSU; the late response must be dropped and flagged.
    do_reset();
    bus.lsu_req  = 1'b1;
    bus.lsu_be   = 'hF;
    bus.lsu_addr = 'h10;
    @(negedge clk);
    check("abort lsu_gnt", 32'(bus.lsu_gnt), 32'd1);
    step();
    drive_idle();
    @(negedge clk);
    #1 rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    check("abort err after reset", 32'(bus.err), 32'd0);
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 'h99999999;
    step();
    drive_idle();
    @(negedge clk);
    check("abort lsu_rvalid", 32'(bus.lsu_rvalid), 32'd0);
    check("abort lsu_rdata", bus.lsu_rdata, 32'd0);
    check("abort err", 32'(bus.err), 32'd1);
    step();

    // Response while IDLE sets a sticky error that survives later traffic.
    do_reset();
    @(negedge clk);
    check("idle err before", 32'(bus.err), 32'd0);
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 'h77777777;
    step();
    drive_idle();
    @(negedge clk);
    check("idle err set", 32'(bus.err), 32'd1);
    check("idle if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("idle lsu_rvalid", 32'(bus.lsu_rvalid), 32'd0);
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 'h40;
    @(negedge clk);
    check("err fetch if_gnt", 32'(bus.if_gnt), 32'd1);
    step();
    drive_idle();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 'h00001234;
    step();
    drive_idle();
    @(negedge clk);
    check("err fetch if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check("err fetch if_rdata", bus.if_rdata, 32'h00001234);
    check("err sticky", 32'(bus.err), 32'd1);
    step();
    @(negedge clk);
    check("err sticky idle", 32'(bus.err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
